// File: rtl/usb_mem_readback.sv
// usb_mem_readback: SDRAM-to-USB readback engine in the mem_clk domain.
// Takes a (start address, burst count) command and issues 8-word read
// bursts to sdrc_core while the video reader is idle. Returned words are
// buffered and streamed to the FT245 side as bytes, low byte first.
// Ports:
//   mem_clk, reset_n (async, active-low)
//   cmd_valid/cmd_ready/cmd_addr/cmd_nburst : readback command
//   mem_idle, mem_rd_req/mem_rd_addr/mem_req_ack : burst request
//   mem_rd_valid/mem_rd_data : returned words (bus shared with video)
//   tx_data/tx_valid/tx_ready : byte stream out
//   busy, done : transfer status
// Optional: READBACK_HDR_EN prepends the header A5,5A,nburst[7:0],nburst[15:8].
module usb_mem_readback #(
  parameter int BURST   = 8,
  parameter int FIFO_AW = 5
) (
  input  logic        mem_clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [24:0] cmd_addr,
  input  logic [15:0] cmd_nburst,
  input  logic        mem_idle,
  output logic        mem_rd_req,
  output logic [24:0] mem_rd_addr,
  input  logic        mem_req_ack,
  input  logic        mem_rd_valid,
  input  logic [15:0] mem_rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam int BW = $clog2(BURST);
  localparam int CW = FIFO_AW + 1;
  localparam logic [CW-1:0] DEPTH   = CW'(2 ** FIFO_AW);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
`ifdef READBACK_HDR_EN
  localparam logic [2:0] S_HDR   = 3'd4;
`endif

  logic [2:0]    r_state;
  logic [24:0]   r_addr;
  logic [15:0]   r_nb;
  logic          r_req;
  logic [BW-1:0] r_wcnt;
  logic [CW-1:0] r_resv;
  logic [CW-1:0] r_cnt;
  logic [FIFO_AW-1:0] r_wp;
  logic [FIFO_AW-1:0] r_rp;
  logic [15:0]   r_mem [2**FIFO_AW];
  logic          r_hi;
  logic          r_done0;

  logic          w_accept;
  logic          w_wr;
  logic          w_rd;
  logic          w_fire;
  logic          w_data_valid;
  logic          w_hdr_act;
  logic          w_hdr_done;
  logic [7:0]    w_hdr_byte;
  logic [15:0]   w_word;
  logic [CW-1:0] w_free;
  logic          w_last;
  logic          w_unused_addr;

  assign w_unused_addr = ^cmd_addr[2:0];

`ifdef READBACK_HDR_EN
  logic [1:0] r_hcnt;

  always_comb begin
    w_hdr_byte = 8'hA5;
    unique case (r_hcnt)
      2'd0: w_hdr_byte = 8'hA5;
      2'd1: w_hdr_byte = 8'h5A;
      2'd2: w_hdr_byte = r_nb[7:0];
      default: w_hdr_byte = r_nb[15:8];
    endcase
  end

  assign w_hdr_act  = (r_state == S_HDR);
  assign w_hdr_done = w_hdr_act & w_fire &
                      (r_hcnt == 2'd3) & (r_nb == 16'd0);
`else
  assign w_hdr_act  = 1'b0;
  assign w_hdr_byte = 8'h00;
  assign w_hdr_done = 1'b0;
`endif

  assign w_accept     = cmd_valid & cmd_ready;
  assign w_wr         = (r_state == S_DATA) & mem_rd_valid;
  assign w_data_valid = (r_cnt != '0);
  assign w_word       = r_mem[r_rp];
  assign w_fire       = tx_valid & tx_ready;
  // A word leaves the buffer once its high byte is taken.
  assign w_rd         = w_fire & ~w_hdr_act & r_hi;
  // Reserved words keep a granted burst from overrunning the buffer.
  assign w_free       = DEPTH - r_cnt - r_resv;
  assign w_last       = (r_state == S_DRAIN) & w_rd & (r_cnt == CW'(1));

  assign tx_valid    = w_hdr_act | w_data_valid;
  assign tx_data     = w_hdr_act    ? w_hdr_byte :
                       w_data_valid ? (r_hi ? w_word[15:8] : w_word[7:0]) :
                                      8'h00;
  assign cmd_ready   = (r_state == S_IDLE) & ~r_done0;
  assign busy        = (r_state != S_IDLE) | r_done0;
  assign done        = r_done0 | w_last | w_hdr_done;
  assign mem_rd_req  = r_req;
  assign mem_rd_addr = r_req ? r_addr : 25'd0;

  always_ff @(posedge mem_clk) begin
    if (w_wr) r_mem[r_wp] <= mem_rd_data;
  end

  always_ff @(posedge mem_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_hi  <= 1'b0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
      if (w_fire & ~w_hdr_act) r_hi <= ~r_hi;
    end
  end

  always_ff @(posedge mem_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_nb    <= '0;
      r_req   <= 1'b0;
      r_wcnt  <= '0;
      r_resv  <= '0;
      r_done0 <= 1'b0;
`ifdef READBACK_HDR_EN
      r_hcnt  <= '0;
`endif
    end else begin
      r_done0 <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr <= {cmd_addr[24:3], 3'b000};
            r_nb   <= cmd_nburst;
`ifdef READBACK_HDR_EN
            r_hcnt  <= 2'd0;
            r_state <= S_HDR;
`else
            if (cmd_nburst != 16'd0) r_state <= S_REQ;
            else r_done0 <= 1'b1;
`endif
          end
        end
`ifdef READBACK_HDR_EN
        S_HDR: begin
          if (w_fire) begin
            r_hcnt <= r_hcnt + 2'd1;
            if (r_hcnt == 2'd3)
              r_state <= (r_nb == 16'd0) ? S_IDLE : S_REQ;
          end
        end
`endif
        S_REQ: begin
          if (!r_req) begin
            if (mem_idle && (w_free >= BURST_C)) r_req <= 1'b1;
          end else if (mem_req_ack) begin
            r_req   <= 1'b0;
            r_resv  <= BURST_C;
            r_wcnt  <= '0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (mem_rd_valid) begin
            r_wcnt <= r_wcnt + 1'b1;
            r_resv <= r_resv - CW'(1);
            if (r_wcnt == BW'(BURST - 1)) begin
              r_nb    <= r_nb - 16'd1;
              r_addr  <= r_addr + 25'(BURST);
              r_state <= (r_nb == 16'd1) ? S_DRAIN : S_REQ;
            end
          end
        end
        S_DRAIN: begin
          if (w_last) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
